// File: rtl/control_unit_pkg.sv
// Branch-prediction types and helpers shared by the control path.
package control_unit_pkg;

  // Two-bit saturating direction counter.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bpstate_t;

  // Counter state after observing one resolved outcome.
  function automatic bpstate_t bp_next(input bpstate_t s, input logic taken);
    bpstate_t r;
    r = s;
    unique case (s)
      SNT: r = taken ? WNT : SNT;
      WNT: r = taken ? WT  : SNT;
      WT:  r = taken ? ST  : WNT;
      ST:  r = taken ? ST  : WT;
      default: r = WNT;
    endcase
    return r;
  endfunction

  // The upper counter bit is the predicted direction.
  function automatic logic bp_predict(input bpstate_t s);
    return (s == WT) || (s == ST);
  endfunction

endpackage

// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the CPU.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/btb.sv
// Direct-mapped branch target buffer: combinational lookup, registered update.
module btb
  import cpu_types_pkg::*;
  import control_unit_pkg::*;
#(
  parameter int ENTRIES = 8
) (
  input  logic  CLK,
  input  logic  RST,
  input  word_t lookup_pc,
  output logic  hit_taken,
  output word_t hit_target,
  input  logic  upd_en,
  input  logic  upd_taken,
  input  word_t upd_pc,
  input  word_t upd_target
);

  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = 32 - IDXW - 2;

  logic            valid_q  [ENTRIES];
  logic [TAGW-1:0] tag_q    [ENTRIES];
  word_t           target_q [ENTRIES];
  bpstate_t        ctr_q    [ENTRIES];

  logic [IDXW-1:0] rd_idx, wr_idx;
  logic [TAGW-1:0] rd_tag, wr_tag;
  logic            wr_hit;

  // Word-aligned instructions: the two low address bits never select anything.
  logic unused_low_bits;
  assign unused_low_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign rd_idx = lookup_pc[IDXW+1:2];
  assign rd_tag = lookup_pc[31:IDXW+2];
  assign wr_idx = upd_pc[IDXW+1:2];
  assign wr_tag = upd_pc[31:IDXW+2];

  // Lookup sees only registered contents, so a same-cycle update is invisible.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned, which would infer a latch.
    hit_taken  = 1'b0;
    hit_target = '0;
    if (valid_q[rd_idx] && tag_q[rd_idx] == rd_tag && bp_predict(ctr_q[rd_idx])) begin
      hit_taken  = 1'b1;
      hit_target = target_q[rd_idx];
    end
  end

  // Resolved instruction hits its own entry when valid and tag agree.
  always_comb begin
    wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
  end

  // Train on every resolved branch: adjust on hit, allocate on taken miss.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // NOTE: this table is reset on purpose; stale valid bits after reset would predict garbage, so it is built from flops rather than RAM.
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= WNT;
      end
    end else if (upd_en) begin
      if (wr_hit) begin
        ctr_q[wr_idx] <= bp_next(ctr_q[wr_idx], upd_taken);
        if (upd_taken) begin
          target_q[wr_idx] <= upd_target;
        end
      end else if (upd_taken) begin
        valid_q[wr_idx]  <= 1'b1;
        tag_q[wr_idx]    <= wr_tag;
        target_q[wr_idx] <= upd_target;
        ctr_q[wr_idx]    <= WT;
      end
    end
  end

endmodule

// File: rtl/fetch_predict.sv
// Fetch stage: PC register, next-PC selection and misprediction recovery.
module fetch_predict
  import cpu_types_pkg::*;
  import control_unit_pkg::*;
#(
  parameter int          ENTRIES  = 8,
  parameter logic [31:0] PC_RESET = 32'h0
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  ihit,
  input  logic  stall,
  input  logic  ex_valid,
  input  logic  ex_taken,
  input  word_t ex_pc,
  input  word_t ex_target,
  input  logic  ex_pred_taken,
  input  word_t ex_pred_target,
  output word_t imemaddr,
  output word_t npc,
  output logic  pred_taken,
  output word_t pred_target,
  output logic  flush
);

  word_t pc_q;
  word_t pc_d;
  logic  mispredict;

  assign imemaddr = pc_q;
  assign npc      = pc_q + 32'd4;

  btb #(.ENTRIES(ENTRIES)) u_btb (
    .CLK        (CLK),
    .RST        (RST),
    .lookup_pc  (pc_q),
    .hit_taken  (pred_taken),
    .hit_target (pred_target),
    .upd_en     (ex_valid),
    .upd_taken  (ex_taken),
    .upd_pc     (ex_pc),
    .upd_target (ex_target)
  );

  // Wrong direction, or right direction with the wrong target.
  always_comb begin
    mispredict = ex_valid &&
                 ((ex_taken != ex_pred_taken) ||
                  (ex_taken && (ex_target != ex_pred_target)));
  end

  assign flush = mispredict;

  // Recovery beats any hold; otherwise follow the prediction or fall through.
  always_comb begin
    pc_d = npc;
    if (mispredict) begin
      pc_d = ex_taken ? ex_target : ex_pc + 32'd4;
    end else if (stall || !ihit) begin
      pc_d = pc_q;
    end else if (pred_taken) begin
      pc_d = pred_target;
    end
  end

  // PC register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q <= PC_RESET;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_predict.sv
// Self-checking bench for fetch_predict: reset vectors, directed corners, random vs model.
module tb_fetch_predict;
  import cpu_types_pkg::*;

  localparam int    ENTRIES  = 8;
  localparam int    IDXW     = 3;
  localparam word_t PC_RESET = 32'h0;

  logic  CLK = 1'b0;
  logic  RST;
  logic  ihit, stall, ex_valid, ex_taken, ex_pred_taken;
  word_t ex_pc, ex_target, ex_pred_target;
  word_t imemaddr, npc, pred_target;
  logic  pred_taken, flush;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_predict #(.ENTRIES(ENTRIES), .PC_RESET(PC_RESET)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .stall(stall),
    .ex_valid(ex_valid), .ex_taken(ex_taken), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .imemaddr(imemaddr), .npc(npc), .pred_taken(pred_taken),
    .pred_target(pred_target), .flush(flush)
  );

  always #5 CLK = ~CLK;

  // Reference model: an array of entries with integer counters 0..3.
  bit    m_valid [ENTRIES];
  word_t m_tag   [ENTRIES];
  word_t m_tgt   [ENTRIES];
  int    m_cnt   [ENTRIES];
  word_t m_pc;

  typedef struct {
    logic  exv, ext, expt;
    word_t tgt, ptgt;
    logic  flush_exp;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input word_t act, input word_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 1;
    end
    m_pc = PC_RESET;
  endfunction

  function automatic void model_lookup(input word_t pc, output bit t, output word_t tg);
    int    idx;
    word_t tag;
    idx = int'((pc / 4) % ENTRIES);
    tag = pc / (4 * ENTRIES);
    t   = m_valid[idx] && (m_tag[idx] == tag) && (m_cnt[idx] >= 2);
    tg  = t ? m_tgt[idx] : 32'h0;
  endfunction

  // One clock: drive at posedge+1, compare at negedge, advance model at posedge.
  task automatic cycle(input logic ih, input logic st, input logic exv, input logic ext,
                       input word_t expc, input word_t extgt, input logic expt, input word_t exptgt);
    bit    p, mis, hit;
    word_t ptgt, nxt, tag;
    int    idx;
    ihit = ih; stall = st; ex_valid = exv; ex_taken = ext; ex_pc = expc;
    ex_target = extgt; ex_pred_taken = expt; ex_pred_target = exptgt;
    @(negedge CLK);
    model_lookup(m_pc, p, ptgt);
    mis = exv && ((ext != expt) || (ext && extgt != exptgt));
    check("imemaddr", imemaddr, m_pc);
    check("npc", npc, m_pc + 32'd4);
    check("pred_taken", 32'(pred_taken), 32'(p));
    check("pred_target", pred_target, ptgt);
    check("flush", 32'(flush), 32'(mis));
    if (mis)             nxt = ext ? extgt : expc + 32'd4;
    else if (st || !ih)  nxt = m_pc;
    else if (p)          nxt = ptgt;
    else                 nxt = m_pc + 32'd4;
    idx = int'((expc / 4) % ENTRIES);
    tag = expc / (4 * ENTRIES);
    hit = m_valid[idx] && (m_tag[idx] == tag);
    @(posedge CLK);
    m_pc = nxt;
    if (exv) begin
      if (hit) begin
        m_cnt[idx] = ext ? ((m_cnt[idx] == 3) ? 3 : m_cnt[idx] + 1)
                         : ((m_cnt[idx] == 0) ? 0 : m_cnt[idx] - 1);
        if (ext) m_tgt[idx] = extgt;
      end else if (ext) begin
        m_valid[idx] = 1; m_tag[idx] = tag; m_tgt[idx] = extgt; m_cnt[idx] = 2;
      end
    end
    #1;
  endtask

  task automatic idle();
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Not-taken resolution of a predicted-taken instruction at a-4 lands on a.
  task automatic redirect(input word_t a);
    cycle(1, 0, 1, 0, a - 32'd4, 32'h0, 1, 32'h0);
  endtask

  task automatic resolve(input word_t pc, input logic t, input word_t tgt, input logic pt, input word_t ptgt);
    cycle(1, 0, 1, t, pc, tgt, pt, ptgt);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    ihit = 1; stall = 0; ex_valid = 0; ex_taken = 0; ex_pc = 0;
    ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
    @(negedge CLK);
    model_reset();
    check("rst_pc", imemaddr, PC_RESET);
    check("rst_pred", 32'(pred_taken), 32'h0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    ihit = 1; stall = 0; ex_valid = 0; ex_taken = 0; ex_pc = 0;
    ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;

    // Flush is purely combinational and must follow inputs even under reset.
    vecs[0] = '{exv:0, ext:1, expt:0, tgt:32'h40, ptgt:32'h00, flush_exp:0};
    vecs[1] = '{exv:1, ext:1, expt:0, tgt:32'h40, ptgt:32'h00, flush_exp:1};
    vecs[2] = '{exv:1, ext:0, expt:1, tgt:32'h40, ptgt:32'h40, flush_exp:1};
    vecs[3] = '{exv:1, ext:1, expt:1, tgt:32'h40, ptgt:32'h40, flush_exp:0};
    vecs[4] = '{exv:1, ext:1, expt:1, tgt:32'h40, ptgt:32'h44, flush_exp:1};
    vecs[5] = '{exv:1, ext:0, expt:0, tgt:32'h40, ptgt:32'h44, flush_exp:0};
    vecs[6] = '{exv:1, ext:1, expt:0, tgt:32'h80, ptgt:32'h80, flush_exp:1};
    for (int i = 0; i < 7; i++) begin
      ex_valid = vecs[i].exv; ex_taken = vecs[i].ext; ex_pred_taken = vecs[i].expt;
      ex_pc = 32'h10; ex_target = vecs[i].tgt; ex_pred_target = vecs[i].ptgt;
      #1;
      check($sformatf("vec%0d_flush", i), 32'(flush), 32'(vecs[i].flush_exp));
      check($sformatf("vec%0d_pc", i), imemaddr, PC_RESET);
      check($sformatf("vec%0d_pred", i), 32'(pred_taken), 32'h0);
      check($sformatf("vec%0d_ptgt", i), pred_target, 32'h0);
    end
    @(posedge CLK);
    #1;
    do_reset();

    // Sequential fetch from reset.
    check("seq_pc0", imemaddr, 32'h0);
    idle(); check("seq_pc4", imemaddr, 32'h4);
    idle(); check("seq_pc8", imemaddr, 32'h8);
    idle(); check("seq_pcC", imemaddr, 32'hC);
    check("seq_nopred", 32'(pred_taken), 32'h0);
    idle(); check("seq_pc10", imemaddr, 32'h10);

    // First taken resolution allocates and redirects; refetch predicts it.
    resolve(32'h10, 1, 32'h40, 0, 32'h0); check("alloc_redir", imemaddr, 32'h40);
    redirect(32'h10);
    check("refetch_pc", imemaddr, 32'h10);
    check("refetch_pred", 32'(pred_taken), 32'h1);
    check("refetch_tgt", pred_target, 32'h40);

    // Two not-taken resolutions from WT: WNT then SNT.
    resolve(32'h10, 0, 32'h0, 1, 32'h40); check("nt1_pc", imemaddr, 32'h14);
    redirect(32'h10); check("wnt_pred", 32'(pred_taken), 32'h0);
    resolve(32'h10, 0, 32'h0, 1, 32'h40); check("nt2_pc", imemaddr, 32'h14);
    resolve(32'h10, 1, 32'h40, 0, 32'h0); check("snt_up_pc", imemaddr, 32'h40);
    redirect(32'h10); check("snt_to_wnt_pred", 32'(pred_taken), 32'h0);
    resolve(32'h10, 1, 32'h40, 0, 32'h0);
    redirect(32'h10); check("wnt_to_wt_pred", 32'(pred_taken), 32'h1);

    // Instruction-memory miss hold, then redirect during the hold.
    redirect(32'h20);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0, 0, 0, 0);
      check($sformatf("ihit_hold%0d", i), imemaddr, 32'h20);
    end
    cycle(0, 0, 1, 1, 32'h74, 32'h48, 0, 32'h0);
    check("hold_redir", imemaddr, 32'h48);

    // Stall holds PC but still trains the BTB exactly once.
    cycle(1, 1, 0, 0, 0, 0, 0, 0); check("stall_hold", imemaddr, 32'h48);
    cycle(1, 1, 1, 1, 32'h10, 32'h40, 1, 32'h40); check("stall_upd_hold", imemaddr, 32'h48);
    cycle(0, 0, 1, 0, 32'h10, 32'h0, 0, 32'h0);
    redirect(32'h10); check("stall_once_pred", 32'(pred_taken), 32'h1);

    // Address wrap.
    redirect(32'hFFFF_FFFC);
    check("wrap_npc", npc, 32'h0);
    idle(); check("wrap_pc", imemaddr, 32'h0);
    redirect(32'h0); check("wrap_redir", imemaddr, 32'h0);

    // Aliasing: 0x30 evicts 0x10 at the same index.
    do_reset();
    resolve(32'h10, 1, 32'h40, 0, 32'h0);
    resolve(32'h30, 1, 32'h50, 0, 32'h0);
    redirect(32'h10); check("alias_miss", 32'(pred_taken), 32'h0);
    redirect(32'h30);
    check("alias_hit", 32'(pred_taken), 32'h1);
    check("alias_tgt", pred_target, 32'h50);

    // Reset mid-stream discards the in-flight allocation.
    ihit = 1; stall = 0; ex_valid = 1; ex_taken = 1; ex_pc = 32'h44;
    ex_target = 32'h88; ex_pred_taken = 0; ex_pred_target = 0;
    #2 RST = 1'b1;
    @(negedge CLK);
    model_reset();
    check("midrst_pc", imemaddr, PC_RESET);
    check("midrst_flush", 32'(flush), 32'h1);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    ex_valid = 0;
    check("midrst_pc_after", imemaddr, PC_RESET);
    redirect(32'h30); check("midrst_miss30", 32'(pred_taken), 32'h0);
    redirect(32'h10); check("midrst_miss10", 32'(pred_taken), 32'h0);
    redirect(32'h44); check("midrst_miss44", 32'(pred_taken), 32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic  ih, st, exv, ext, pt;
      word_t pc, tg, ptg;
      bit    mp;
      word_t mt;
      ih  = ($urandom_range(0, 9) != 0);
      st  = ($urandom_range(0, 4) == 0);
      exv = ($urandom_range(0, 2) == 0);
      ext = $urandom_range(0, 1) == 1;
      pc  = word_t'($urandom_range(0, 31)) << 2;
      tg  = word_t'($urandom_range(0, 63)) << 2;
      model_lookup(pc, mp, mt);
      if ($urandom_range(0, 1) == 1) begin
        pt = mp; ptg = mt;
      end else begin
        pt = $urandom_range(0, 1) == 1;
        ptg = ($urandom_range(0, 1) == 1) ? tg : word_t'($urandom_range(0, 63)) << 2;
      end
      cycle(ih, st, exv, ext, pc, tg, pt, ptg);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
